// File: rtl/mem_pkg.sv
// Shared memory-subsystem types and default sizing for the RAM arbiter slice.
package mem_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_e;

  localparam int unsigned DEF_NREQ       = 4;
  localparam int unsigned DEF_DATA_WIDTH = 10;
  localparam int unsigned DEF_ADDR_WIDTH = 14;
  localparam int unsigned DEF_WORDS      = 32;

  // Longest burst a winner may hold: one line writeback plus one line refill plus one.
  function automatic int unsigned max_burst(input int unsigned words);
    return 2 * words + 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1, wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [LW-1:0]   winner,
  output logic            valid
);

  always_comb begin
    int unsigned idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(last) + 1 + k) % NREQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = LW'(idx);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port among NREQ caches; the winner owns the RAM for a whole burst.
module ram_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned NREQ       = DEF_NREQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned WORDS      = DEF_WORDS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            rd,
  input  logic [NREQ-1:0]            wr,
  input  logic [NREQ*ADDR_WIDTH-1:0] addr,
  input  logic [NREQ*DATA_WIDTH-1:0] wdata,
  output logic [NREQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       busy,
  output logic [ADDR_WIDTH-1:0]      ram_addr,
  output logic                       ram_read,
  output logic                       ram_write,
  output logic [DATA_WIDTH-1:0]      ram_data_in,
  input  logic [DATA_WIDTH-1:0]      ram_data_out
);

  localparam int unsigned LW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW   = $clog2(2 * WORDS + 2);
  localparam int unsigned MAXB = max_burst(WORDS);

  arb_state_e      state, state_next;
  logic [NREQ-1:0] grant_next;
  logic [LW-1:0]   last, last_next, pick;
  logic            pick_valid;
  logic [CW-1:0]   cnt, cnt_next;

  logic                  win_req, win_rd, win_wr, win_strobe;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  rr_pick #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_pick (
    .req    (req),
    .last   (last),
    .winner (pick),
    .valid  (pick_valid)
  );

  // While bursting, last holds the granted index, so it doubles as the mux select.
  assign win_req    = req[last];
  assign win_rd     = rd[last];
  assign win_wr     = wr[last];
  assign win_strobe = win_rd | win_wr;
  assign win_addr   = addr[32'(last) * ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wdata  = wdata[32'(last) * DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    last_next   = last;
    cnt_next    = cnt;
    ram_read    = 1'b0;
    ram_write   = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next       = BURST;
          grant_next       = '0;
          grant_next[pick] = 1'b1;
          last_next        = pick;
          cnt_next         = '0;
        end
      end
      BURST: begin
        ram_write   = win_wr;
        ram_read    = win_rd & ~win_wr;
        ram_addr    = win_strobe ? win_addr : '0;
        ram_data_in = win_wr ? win_wdata : '0;
        if (win_strobe && cnt != CW'(MAXB)) begin
          cnt_next = cnt + CW'(1);
        end
        // Release when the owner lets go or on the access that exhausts the burst budget.
        if (!win_req || cnt_next == CW'(MAXB)) begin
          state_next = IDLE;
          grant_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= LW'(NREQ - 1);
      cnt   <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      last  <= last_next;
      cnt   <= cnt_next;
    end
  end

  assign busy  = |grant;
  assign rdata = ram_data_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a queue-based ownership model predicts grant changes and RAM accesses.
module tb_ram_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 10;
  localparam int unsigned AW   = 14;
  localparam int unsigned WDS  = 32;
  localparam int          MAXB = 2 * WDS + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0, rd = '0, wr = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic [NREQ-1:0]   grant;
  logic [DW-1:0]     rdata;
  logic              busy;
  logic [AW-1:0]     ram_addr;
  logic              ram_read, ram_write;
  logic [DW-1:0]     ram_data_in;
  logic [DW-1:0]     ram_data_out = '0;

  ram_arbiter #(
    .NREQ       (NREQ),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .WORDS      (WDS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .rd           (rd),
    .wr           (wr),
    .addr         (addr),
    .wdata        (wdata),
    .grant        (grant),
    .rdata        (rdata),
    .busy         (busy),
    .ram_addr     (ram_addr),
    .ram_read     (ram_read),
    .ram_write    (ram_write),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  // Stand-in RAM: registered read data derived from the address.
  always @(posedge clk) if (ram_read) ram_data_out <= DW'(ram_addr) ^ 10'h2A5;

  typedef struct {
    logic          w;
    logic          r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } acc_t;

  acc_t            acc_q[$];
  logic [NREQ-1:0] gnt_q[$];

  int passed = 0;
  int total  = 0;

  int m_owner, m_last, m_cnt;
  bit m_busy;
  bit mon_en = 1'b0;
  logic [NREQ-1:0] prev_grant = '0;
  bit active[NREQ];
  int left[NREQ];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
    m_cnt   = 0;
    m_busy  = 1'b0;
    acc_q.delete();
    gnt_q.delete();
    for (int i = 0; i < NREQ; i++) begin
      active[i] = 1'b0;
      left[i]   = 0;
    end
  endtask

  // Ownership model: one owner at a time, release on req drop or after MAXB accesses,
  // and a fresh round-robin search starting after the previous owner.
  task automatic model_step();
    acc_t e;
    m_busy = (m_owner >= 0);
    if (m_owner >= 0) begin
      int o = m_owner;
      if (rd[o] || wr[o]) begin
        e.w = wr[o];
        e.r = rd[o] && !wr[o];
        e.a = addr[o*AW +: AW];
        e.d = wr[o] ? wdata[o*DW +: DW] : '0;
        acc_q.push_back(e);
        if (m_cnt < MAXB) m_cnt++;
      end
      if (!req[o] || m_cnt == MAXB) begin
        m_owner = -1;
        gnt_q.push_back('0);
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int idx = (m_last + 1 + k) % NREQ;
        if (m_owner < 0 && req[idx]) begin
          logic [NREQ-1:0] oh;
          oh = '0;
          oh[idx] = 1'b1;
          m_owner = idx;
          m_last  = idx;
          m_cnt   = 0;
          gnt_q.push_back(oh);
        end
      end
    end
  endtask

  task automatic step(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                      input logic [AW-1:0] a0, input logic [DW-1:0] d0, input logic [AW-1:0] a2);
    req = rq;
    rd  = r;
    wr  = w;
    for (int i = 0; i < NREQ; i++) begin
      addr[i*AW +: AW]  = AW'($urandom);
      wdata[i*DW +: DW] = DW'($urandom);
    end
    addr[0 +: AW]   = a0;
    wdata[0 +: DW]  = d0;
    addr[2*AW +: AW] = a2;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int c = 0; c < n; c++) step('0, '0, '0, AW'($urandom), DW'($urandom), AW'($urandom));
    for (int i = 0; i < NREQ; i++) begin
      active[i] = 1'b0;
      left[i]   = 0;
    end
  endtask

  // Cache behaviour: once granted, perform a burst of lo..hi strobe cycles, then drop req for one cycle.
  task automatic run(input int cycles, input logic [NREQ-1:0] want, input int lo, input int hi, input bit noisy);
    logic [NREQ-1:0] rq, r, w;
    for (int c = 0; c < cycles; c++) begin
      rq = want;
      r  = '0;
      w  = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          if (!active[i]) begin
            active[i] = 1'b1;
            left[i]   = $urandom_range(hi, lo);
          end
          if (left[i] == 0) begin
            rq[i]     = 1'b0;
            active[i] = 1'b0;
          end else begin
            left[i]--;
            if (noisy) begin
              r[i] = 1'($urandom_range(1, 0));
              w[i] = 1'($urandom_range(1, 0));
            end else r[i] = 1'b1;
          end
        end else if (noisy) begin
          r[i] = 1'($urandom_range(1, 0));
          w[i] = 1'($urandom_range(1, 0));
        end
      end
      step(rq, r, w, AW'($urandom), DW'($urandom), AW'($urandom));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (grant !== prev_grant) begin
        if (gnt_q.size() == 0) chk("grant_unexpected", grant, prev_grant);
        else chk("grant", grant, gnt_q.pop_front());
        prev_grant = grant;
      end
      chk("busy", busy, m_busy);
      chk("rdata", rdata, ram_data_out);
      if (ram_read || ram_write) begin
        if (acc_q.size() == 0) begin
          chk("access_unexpected", {ram_read, ram_write}, 2'b00);
        end else begin
          acc_t e;
          e = acc_q.pop_front();
          chk("ram_write", ram_write, e.w);
          chk("ram_read", ram_read, e.r);
          chk("ram_addr", ram_addr, e.a);
          if (e.w) chk("ram_data_in", ram_data_in, e.d);
        end
      end else begin
        chk("idle_addr", ram_addr, '0);
        chk("idle_data", ram_data_in, '0);
      end
    end
  end

  initial begin
    model_reset();
    #1;
    chk("reset_grant", grant, '0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_read", ram_read, 1'b0);
    chk("reset_write", ram_write, 1'b0);
    chk("reset_addr", ram_addr, '0);
    chk("reset_data", ram_data_in, '0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    prev_grant = '0;
    mon_en     = 1'b1;

    // Single requester: grant, a few reads, release, dead cycle.
    step(4'b0001, '0, '0, 14'h0, 10'h0, 14'h0);
    for (int c = 0; c < 3; c++) step(4'b0001, 4'b0001, '0, AW'($urandom), DW'($urandom), AW'($urandom));
    idle_steps(2);

    // Read+write together from the winner; writes from requester 2 while not granted.
    step(4'b0001, '0, '0, 14'h0, 10'h0, 14'h0);
    step(4'b0001, 4'b0001, 4'b0001, 14'h0123, 10'h2AA, 14'h3FFF);
    step(4'b0001, '0, 4'b0100, 14'h0011, 10'h155, 14'h3FFF);
    step(4'b0001, 4'b0001, 4'b0100, 14'h0055, 10'h000, 14'h3FFF);
    idle_steps(2);

    // All four requesting, 32-read bursts each.
    run(5 * 34 + 6, 4'b1111, 32, 32, 1'b0);
    idle_steps(3);

    // Bursts longer than the budget force release to the other waiting requester.
    run(160, 4'b0011, 70, 70, 1'b0);
    idle_steps(3);

    // Reset in the middle of a burst, then a fresh arbitration from requester 3.
    step(4'b0001, '0, '0, 14'h0, 10'h0, 14'h0);
    for (int c = 0; c < 10; c++) step(4'b0001, 4'b0001, '0, AW'($urandom), DW'($urandom), AW'($urandom));
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_grant", grant, '0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_read", ram_read, 1'b0);
    chk("midrst_write", ram_write, 1'b0);
    rst = 1'b0;
    req = '0;
    rd  = '0;
    wr  = '0;
    model_reset();
    @(posedge clk);
    #1;
    prev_grant = '0;
    mon_en     = 1'b1;
    step(4'b1000, '0, '0, 14'h0, 10'h0, 14'h0);
    step(4'b1000, 4'b1000, '0, 14'h0, 10'h0, 14'h0);
    idle_steps(2);

    // Randomized mixed traffic.
    for (int p = 0; p < 8; p++) begin
      int lo = $urandom_range(20, 0);
      run(90, NREQ'($urandom_range(15, 1)), lo, lo + $urandom_range(60, 0), 1'b1);
      idle_steps(3);
    end

    @(negedge clk);
    #1;
    chk("grant_queue_drained", gnt_q.size(), 0);
    chk("access_queue_drained", acc_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
